demux_stream: RTL and testbench

DEMUX_STREAM -- requirements
Module: demux_stream

---
 rtl/demux_pkg.sv | 7 +
 rtl/demux_chan_reg.sv | 44 ++++
 rtl/demux_stream.sv | 80 ++++++++
 tb/tb_demux_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults for the stream demultiplexer: word width, channel count and
// drop-counter width.
package demux_pkg;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;
  localparam int DROP_CNT_W   = 16;
endpackage

// File: rtl/demux_chan_reg.sv
// One-entry register slice holding the current word for a single output channel.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ZERO_IDLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A write in the same cycle as a drain replaces the word without a bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = ((ZERO_IDLE != 0) && !valid_q) ? '0 : data_q;

endmodule

// File: rtl/demux_stream.sv
// Routes a valid/ready input stream to one of CHANNELS output slices chosen by
// sel; out-of-range selections are discarded and counted.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int ZERO_IDLE = 1,
  localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          x,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      enable,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      drop,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  logic [31:0]           sel_ext;
  logic                  in_range;
  logic                  xfer;
  logic [CHANNELS-1:0]   sel_hit;
  logic [CHANNELS-1:0]   wr_en;
  logic                  drop_q, drop_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Only the addressed channel's ready can stall the input, so other channels'
  // out_ready never reaches in_ready.
  always_comb begin
    sel_ext  = 32'(sel);
    in_range = sel_ext < 32'(CHANNELS);
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (sel_ext == 32'(k));
    end
    in_ready   = enable && !rst && !(|(sel_hit & out_valid & ~out_ready));
    xfer       = in_valid && in_ready;
    wr_en      = sel_hit & {CHANNELS{xfer}};
    drop_d     = xfer && !in_range;
    drop_cnt_d = drop_d ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    demux_chan_reg #(
      .WIDTH    (WIDTH),
      .ZERO_IDLE(ZERO_IDLE)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[k]),
      .wr_data  (x),
      .out_data (out_data[k*WIDTH +: WIDTH]),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel instance checked cycle by cycle against a
// per-channel word model, and a 3-channel instance for out-of-range drops.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  x4 = '0;
  logic [1:0]  sel4 = '0;
  logic        en4 = 1'b0, iv4 = 1'b0;
  logic [3:0]  rdy4 = '0;
  logic        ir4, dr4;
  logic [31:0] od4;
  logic [3:0]  ov4;
  logic [15:0] dc4;

  logic [7:0]  x3 = '0;
  logic [1:0]  sel3 = '0;
  logic        en3 = 1'b0, iv3 = 1'b0;
  logic [2:0]  rdy3 = '0;
  logic        ir3, dr3;
  logic [23:0] od3;
  logic [2:0]  ov3;
  logic [15:0] dc3;

  demux_stream #(.WIDTH(8), .CHANNELS(4), .ZERO_IDLE(1)) dut4 (
    .clk(clk), .rst(rst), .x(x4), .sel(sel4), .enable(en4), .in_valid(iv4),
    .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(rdy4),
    .drop(dr4), .drop_cnt(dc4)
  );

  demux_stream #(.WIDTH(8), .CHANNELS(3), .ZERO_IDLE(1)) dut3 (
    .clk(clk), .rst(rst), .x(x3), .sel(sel3), .enable(en3), .in_valid(iv3),
    .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(rdy3),
    .drop(dr3), .drop_cnt(dc3)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the word each channel currently presents (4-channel DUT).
  bit         mv[4];
  logic [7:0] md[4];
  logic [7:0] del1[$];

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
    del1 = {};
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick4();
    logic        exp_ir;
    logic [3:0]  ev;
    logic [31:0] ed;
    #1;
    exp_ir = en4 && !(mv[sel4] && !rdy4[sel4]);
    checks++;
    if (ir4 !== exp_ir) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b (sel=%0d)", ir4, exp_ir, sel4);
    end
    if (ov4[1] && rdy4[1]) del1.push_back(od4[15:8]);
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (mv[k] && rdy4[k]) mv[k] = 0;
    if (iv4 && exp_ir) begin
      mv[sel4] = 1;
      md[sel4] = x4;
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      ev[k]        = mv[k];
      ed[k*8 +: 8] = mv[k] ? md[k] : 8'h00;
    end
    checks++;
    if (ov4 !== ev || od4 !== ed || dr4 !== 1'b0) begin
      errors++;
      $display("FAIL outputs: got valid=%b data=%h drop=%b expected valid=%b data=%h drop=0",
               ov4, od4, dr4, ev, ed);
    end
    @(negedge clk);
  endtask

  task automatic drive4(input logic en, input logic iv, input logic [1:0] s,
                        input logic [7:0] d, input logic [3:0] r);
    en4 = en; iv4 = iv; sel4 = s; x4 = d; rdy4 = r;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ov4 !== 4'b0 || od4 !== 32'h0 || dc4 !== 16'h0 || dr4 !== 1'b0 || ir4 !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset: got valid=%b data=%h cnt=%h drop=%b ready=%b expected all 0",
               ov4, od4, dc4, dr4, ir4);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    drive4(1, 1, 2'd1, 8'h5A, 4'b0000); tick4();
    drive4(1, 1, 2'd3, 8'hC3, 4'b0000); tick4();
    drive4(1, 0, 2'd0, 8'h00, 4'b0000); tick4();
    checks++;
    if (ov4 !== 4'b1010) begin
      errors++;
      $display("FAIL preload_valid: got %b expected 1010", ov4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov4 !== 4'b0 || od4 !== 32'h0 || dc4 !== 16'h0 || ir4 !== 1'b0 || ov3 !== 3'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b data=%h cnt=%h ready=%b expected all 0",
               ov4, od4, dc4, ir4);
    end
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 4'b0 || od4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: got valid=%b data=%h expected 0", ov4, od4);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_routing();
    drive4(1, 1, 2'd2, 8'hA5, 4'b1111); tick4();
    checks++;
    if (ov4 !== 4'b0100 || od4 !== 32'h00A5_0000) begin
      errors++;
      $display("FAIL routing: got valid=%b data=%h expected 0100 / 00a50000", ov4, od4);
    end
    drive4(1, 0, 2'd0, 8'h00, 4'b1111); tick4();
  endtask

  task automatic test_backpressure();
    del1 = {};
    drive4(1, 1, 2'd1, 8'h11, 4'b1101); tick4();
    drive4(1, 1, 2'd1, 8'h22, 4'b1101); tick4(); tick4();
    checks++;
    if (od4[15:8] !== 8'h11 || ir4 !== 1'b0) begin
      errors++;
      $display("FAIL stall: got ch1=%h in_ready=%b expected 11 / 0", od4[15:8], ir4);
    end
    drive4(1, 1, 2'd1, 8'h22, 4'b1111); tick4();
    drive4(1, 0, 2'd1, 8'h00, 4'b1111); tick4(); tick4();
    checks++;
    if (del1.size() != 2 || del1[0] !== 8'h11 || del1[1] !== 8'h22) begin
      errors++;
      $display("FAIL delivery_order: got %0d words first=%h expected 2 words 11,22",
               del1.size(), (del1.size() > 0) ? del1[0] : 8'hxx);
    end
  endtask

  task automatic test_enable_gate();
    drive4(1, 1, 2'd0, 8'h01, 4'b0000); tick4();
    drive4(1, 1, 2'd2, 8'h02, 4'b0000); tick4();
    for (int i = 0; i < 5; i++) begin
      drive4(0, 1, 2'($urandom_range(3)), 8'($urandom), 4'b1111);
      tick4();
    end
    checks++;
    if (ov4 !== 4'b0000) begin
      errors++;
      $display("FAIL enable_drain: got valid=%b expected 0000", ov4);
    end
  endtask

  task automatic test_streaming();
    logic [1:0] s;
    logic [7:0] d;
    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(3));
      d = 8'($urandom);
      drive4(1, 1, s, d, 4'b1111);
      tick4();
      checks++;
      if (ov4[s] !== 1'b1 || od4[s*8 +: 8] !== d) begin
        errors++;
        $display("FAIL stream_word: got ch%0d valid=%b data=%h expected 1 / %h",
                 s, ov4[s], od4[s*8 +: 8], d);
      end
    end
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 200; i++) begin
      drive4(($urandom_range(7) != 0), 1'($urandom), 2'($urandom_range(3)),
             8'($urandom), 4'($urandom));
      tick4();
    end
    drive4(1, 0, 2'd0, 8'h00, 4'b1111); tick4(); tick4();
  endtask

  task automatic test_out_of_range();
    int pulses = 0;
    en3 = 1; rdy3 = 3'b110; iv3 = 1; sel3 = 2'd0; x3 = 8'h77;
    @(posedge clk); #1;
    checks++;
    if (ov3 !== 3'b001 || od3 !== 24'h000077) begin
      errors++;
      $display("FAIL dut3_load: got valid=%b data=%h expected 001 / 000077", ov3, od3);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      iv3 = 1; sel3 = 2'd3; x3 = 8'($urandom);
      #1;
      checks++;
      if (ir3 !== 1'b1) begin
        errors++;
        $display("FAIL oor_ready: got %b expected 1", ir3);
      end
      @(posedge clk); #1;
      if (dr3 === 1'b1) pulses++;
      checks++;
      if (ov3 !== 3'b001 || od3 !== 24'h000077) begin
        errors++;
        $display("FAIL oor_hold: got valid=%b data=%h expected 001 / 000077", ov3, od3);
      end
      @(negedge clk);
      iv3 = 0;
      @(posedge clk); #1;
      checks++;
      if (dr3 !== 1'b0) begin
        errors++;
        $display("FAIL drop_width: got drop=%b expected 0 one cycle after", dr3);
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 3 || dc3 !== 16'd3) begin
      errors++;
      $display("FAIL drop_count: got pulses=%0d cnt=%0d expected 3 / 3", pulses, dc3);
    end
    en3 = 0; iv3 = 1; sel3 = 2'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ir3 !== 1'b0) begin
        errors++;
        $display("FAIL gated_ready: got %b expected 0", ir3);
      end
      @(posedge clk); #1;
      checks++;
      if (dr3 !== 1'b0 || dc3 !== 16'd3) begin
        errors++;
        $display("FAIL gated_drop: got drop=%b cnt=%0d expected 0 / 3", dr3, dc3);
      end
      @(negedge clk);
    end
    iv3 = 0; en3 = 1;
    force dut3.drop_cnt_q = 16'hFFFF;
    #1 release dut3.drop_cnt_q;
    @(negedge clk);
    iv3 = 1; sel3 = 2'd3;
    @(posedge clk); #1;
    checks++;
    if (dr3 !== 1'b1 || dc3 !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate: got drop=%b cnt=%h expected 1 / ffff", dr3, dc3);
    end
    @(negedge clk);
    iv3 = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_routing();
    test_backpressure();
    test_enable_gate();
    test_streaming();
    test_random_mix();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
